// File: rtl/sdram_arbiter.sv
// Two-port round-robin arbiter in front of a single-command SDRAM controller.
// One operation in flight at a time, guarded by a watchdog that sets a sticky error.
module sdram_arbiter #(
  parameter int ADDR_W  = 24,
  parameter int DATA_W  = 16,
  parameter int TIMEOUT = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              p0_req,
  input  logic              p0_we,
  input  logic [ADDR_W-1:0] p0_addr,
  input  logic [DATA_W-1:0] p0_wdata,
  output logic              p0_gnt,
  output logic              p0_done,
  input  logic              p1_req,
  input  logic              p1_we,
  input  logic [ADDR_W-1:0] p1_addr,
  input  logic [DATA_W-1:0] p1_wdata,
  output logic              p1_gnt,
  output logic              p1_done,
  output logic [DATA_W-1:0] rdata,
  output logic              ctrl_req,
  output logic              ctrl_we,
  output logic [ADDR_W-1:0] ctrl_addr,
  output logic [DATA_W-1:0] ctrl_wdata,
  input  logic              ctrl_ack,
  input  logic              ctrl_done,
  input  logic [DATA_W-1:0] ctrl_rdata,
  output logic              err
);

  typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, WAIT = 2'd2} state_t;

  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);

  state_t      state_q;
  logic        last_q;
  logic        served_q;
  logic [15:0] cnt_q;
  logic        win_d;
  logic        any_req_d;
  logic        finish_d;
  logic        expire_d;

  // Round-robin winner and completion/timeout conditions for the current cycle.
  always_comb begin
    any_req_d = p0_req | p1_req;
    if (p0_req && p1_req) begin
      win_d = ~last_q;
    end else if (p1_req) begin
      win_d = 1'b1;
    end else begin
      win_d = 1'b0;
    end
    finish_d = ((state_q == ISSUE) && ctrl_ack && ctrl_done) ||
               ((state_q == WAIT) && ctrl_done);
    expire_d = !finish_d && (state_q != IDLE) && (cnt_q >= TMO_LAST);
  end

  // Control FSM; every output is a register updated here.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      last_q     <= 1'b1;
      served_q   <= 1'b0;
      cnt_q      <= 16'd0;
      p0_gnt     <= 1'b0;
      p1_gnt     <= 1'b0;
      p0_done    <= 1'b0;
      p1_done    <= 1'b0;
      rdata      <= '0;
      ctrl_req   <= 1'b0;
      ctrl_we    <= 1'b0;
      ctrl_addr  <= '0;
      ctrl_wdata <= '0;
      err        <= 1'b0;
    end else begin
      p0_gnt  <= 1'b0;
      p1_gnt  <= 1'b0;
      p0_done <= 1'b0;
      p1_done <= 1'b0;
      case (state_q)
        IDLE: begin
          // Controller strobes are ignored here; only requests matter.
          if (any_req_d) begin
            ctrl_we    <= win_d ? p1_we    : p0_we;
            ctrl_addr  <= win_d ? p1_addr  : p0_addr;
            ctrl_wdata <= win_d ? p1_wdata : p0_wdata;
            ctrl_req   <= 1'b1;
            p0_gnt     <= ~win_d;
            p1_gnt     <= win_d;
            last_q     <= win_d;
            served_q   <= win_d;
            cnt_q      <= 16'd0;
            state_q    <= ISSUE;
          end else begin
            state_q <= IDLE;
          end
        end
        ISSUE, WAIT: begin
          if (finish_d || expire_d) begin
            ctrl_req <= 1'b0;
            p0_done  <= ~served_q;
            p1_done  <= served_q;
            if (finish_d && !ctrl_we) begin
              rdata <= ctrl_rdata;
            end else begin
              rdata <= rdata;
            end
            if (expire_d) begin
              err <= 1'b1;
            end else begin
              err <= err;
            end
            state_q <= IDLE;
          end else begin
            cnt_q <= cnt_q + 16'd1;
            if ((state_q == ISSUE) && ctrl_ack) begin
              ctrl_req <= 1'b0;
              state_q  <= WAIT;
            end else begin
              state_q <= state_q;
            end
          end
        end
        default: begin
          ctrl_req <= 1'b0;
          state_q  <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/sdram_arbiter.md
SDRAM_ARBITER -- requirements
Module: sdram_arbiter

Interface
REQ-001 Parameter ADDR_W, default 24, SDRAM word address width.
REQ-002 Parameter DATA_W, default 16, SDRAM data width.
REQ-003 Parameter TIMEOUT, default 1024, max cycles to wait for completion (range 2..65535).
REQ-004 clk  in  1  single system clock; all logic on rising edge.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 pN_req  in  1  request from port N (N=0,1); held until pN_gnt.
REQ-007 pN_we  in  1  1=write, 0=read; valid while pN_req.
REQ-008 pN_addr  in  ADDR_W  word address; valid while pN_req.
REQ-009 pN_wdata  in  DATA_W  write data; valid while pN_req.
REQ-010 pN_gnt  out  1  one-cycle pulse: port N request captured.
REQ-011 pN_done  out  1  one-cycle pulse: port N operation finished.
REQ-012 rdata  out  DATA_W  read data, valid with pN_done of a read.
REQ-013 ctrl_req  out  1  command request to SDRAM controller.
REQ-014 ctrl_we, ctrl_addr, ctrl_wdata  out  1/ADDR_W/DATA_W  latched command fields.
REQ-015 ctrl_ack  in  1  controller accepted command.
REQ-016 ctrl_done  in  1  controller completed command.
REQ-017 ctrl_rdata  in  DATA_W  read data, valid with ctrl_done.
REQ-018 err  out  1  sticky timeout flag.

Function
REQ-019 FSM states SHALL be IDLE, ISSUE, WAIT.
REQ-020 IDLE: if any pN_req=1, capture winner's we/addr/wdata into ctrl_* registers, go ISSUE; gnt pulse and ctrl_req=1 appear the following cycle (1-cycle req-to-gnt latency).
REQ-021 Arbitration round-robin: single requester wins; both requesting -> port not served last wins; last-served register updates at capture.
REQ-022 ISSUE: hold ctrl_req=1 and ctrl_* stable until ctrl_ack=1; on ack drop ctrl_req next cycle, go WAIT.
REQ-023 ctrl_ack and ctrl_done same cycle in ISSUE: treat as completion, skip WAIT, finish as REQ-024.
REQ-024 WAIT: on ctrl_done register ctrl_rdata into rdata, pulse served port's pN_done one cycle, return IDLE.
REQ-025 rdata SHALL hold its value until the next read completion; unchanged by writes.
REQ-026 Earliest next capture: IDLE cycle after pN_done; back-to-back throughput one op per (3 + controller latency) cycles minimum.
REQ-027 Requester dropping pN_req before pN_gnt: request discarded, no gnt; no effect on in-flight op.
REQ-028 pN_req still high in the cycle after pN_gnt is NOT a new request until pN_done; a req held through pN_done is treated as a new request.
REQ-029 Watchdog: 16-bit counter cleared on entry to ISSUE, increments each cycle in ISSUE/WAIT; reaching TIMEOUT -> err=1, ctrl_req=0, pN_done pulse (rdata unchanged), return IDLE.
REQ-030 err clears only on rst.
REQ-031 ctrl_ack/ctrl_done in IDLE SHALL be ignored.

Reset
REQ-032 rst=1 SHALL force state IDLE, last-served=port 1 (port 0 wins first tie), counter 0, all outputs 0 (gnt, done, ctrl_req, ctrl_we, ctrl_addr, ctrl_wdata, rdata, err).
REQ-033 rst mid-operation SHALL abort without any done pulse; requests pending at deassertion arbitrated from cycle after.

Verification
REQ-034 Single read p0 addr 0x000123, controller ack +1, done +4 with rdata 0xBEEF -> p0_gnt, ctrl_addr 0x000123 ctrl_we 0, p0_done with rdata 0xBEEF.
REQ-035 p0 and p1 requesting continuously from reset -> grants alternate p0,p1,p0,p1; never two captures without an intervening done.
REQ-036 Write p1 addr 0xFFFFFF data 0x1234 with ack and done same cycle -> p1_done next cycle, no WAIT dwell, rdata unchanged.
REQ-037 TIMEOUT=8, controller never asserts done -> err=1 after 8 cycles, pN_done pulse, ctrl_req 0, next request still served.
REQ-038 rst asserted in WAIT -> all outputs 0 next cycle, no pN_done, p0 request after rst released granted first.
